// File: rtl/run_arbiter.sv
// run_arbiter: two-requester round-robin front end for a shared compute unit.
// A granted job is issued with a one-cycle u_start, followed through the unit's
// active window, and its result is captured when the unit drops active.
// Optional build macro: RUN_TIMEOUT_EN aborts a job that spends TIMEOUT cycles
// in WAIT_ACT plus RUN (err pulse alongside done, result left untouched).
// Without the macro the block waits indefinitely and err0/err1 are tied low.
module run_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [1:0] on0,
    input  logic [1:0] on1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] res_y,
    output logic [2:0] res_s,
    output logic       res_b,
    output logic [7:0] u_x,
    output logic [1:0] u_on,
    output logic       u_start,
    input  logic       u_active,
    input  logic [7:0] u_y,
    input  logic [2:0] u_s,
    input  logic       u_b,
    output logic       busy,
    output logic       gnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_ACT = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t     state_r;
    logic       pick_s;
    logic [7:0] pick_x_s;
    logic [1:0] pick_on_s;

    // Round-robin choice: contention goes to the requester not served last
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = ~gnt;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    assign pick_x_s  = pick_s ? x1  : x0;
    assign pick_on_s = pick_s ? on1 : on0;

`ifdef RUN_TIMEOUT_EN
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       timeout_s;

    assign cnt_next_s = cnt_r + 8'd1;
    assign timeout_s  = (cnt_next_s >= 8'(TIMEOUT));
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    // Job sequencer: arbitration, issue handshake, active tracking, result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            u_start <= 1'b0;
            u_x     <= 8'd0;
            u_on    <= 2'd0;
            res_y   <= 8'd0;
            res_s   <= 3'd0;
            res_b   <= 1'b0;
            busy    <= 1'b0;
            gnt     <= 1'b1;
`ifdef RUN_TIMEOUT_EN
            cnt_r   <= 8'd0;
            err0    <= 1'b0;
            err1    <= 1'b0;
`endif
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            u_start <= 1'b0;
`ifdef RUN_TIMEOUT_EN
            err0    <= 1'b0;
            err1    <= 1'b0;
`endif
            case (state_r)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_r <= S_ISSUE;
                        gnt     <= pick_s;
                        u_x     <= pick_x_s;
                        u_on    <= pick_on_s;
                        u_start <= 1'b1;
                        ack0    <= ~pick_s;
                        ack1    <= pick_s;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_WAIT_ACT;
`ifdef RUN_TIMEOUT_EN
                    cnt_r   <= 8'd0;
`endif
                end
                S_WAIT_ACT: begin
`ifdef RUN_TIMEOUT_EN
                    cnt_r <= cnt_next_s;
                    if (timeout_s) begin
                        state_r <= S_DONE;
                        done0   <= ~gnt;
                        done1   <= gnt;
                        err0    <= ~gnt;
                        err1    <= gnt;
                    end else if (u_active) begin
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_WAIT_ACT;
                    end
`else
                    if (u_active) begin
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_WAIT_ACT;
                    end
`endif
                end
                S_RUN: begin
`ifdef RUN_TIMEOUT_EN
                    cnt_r <= cnt_next_s;
`endif
                    if (!u_active) begin
                        state_r <= S_DONE;
                        res_y   <= u_y;
                        res_s   <= u_s;
                        res_b   <= u_b;
                        done0   <= ~gnt;
                        done1   <= gnt;
`ifdef RUN_TIMEOUT_EN
                    end else if (timeout_s) begin
                        state_r <= S_DONE;
                        done0   <= ~gnt;
                        done1   <= gnt;
                        err0    <= ~gnt;
                        err1    <= gnt;
`endif
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_arbiter.sv
// Directed bench for run_arbiter: a table of jobs with hand-computed grants and
// results, plus hand sequences for the timeout and mid-job reset corners.
module tb_run_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [1:0] on0, on1;
    logic       ack0, ack1, done0, done1, err0, err1;
    logic [7:0] res_y;
    logic [2:0] res_s;
    logic       res_b;
    logic [7:0] u_x;
    logic [1:0] u_on;
    logic       u_start;
    logic       u_active;
    logic [7:0] u_y;
    logic [2:0] u_s;
    logic       u_b;
    logic       busy, gnt;

    int n_pass  = 0;
    int n_total = 0;

    // last result the bench expects to see held on res_*
    logic [7:0] py;
    logic [2:0] ps;
    logic       pb;

    typedef struct packed {
        logic       rb;   // pulse reset before this job
        logic       r0;
        logic       r1;
        logic [7:0] x0;
        logic [7:0] x1;
        logic [1:0] o0;
        logic [1:0] o1;
        logic [3:0] act;  // cycles u_active is held high
        logic [7:0] y;
        logic [2:0] s;
        logic       b;
        logic       eg;   // expected grant
        logic [7:0] ex;   // expected u_x
        logic [1:0] eo;   // expected u_on
    } vec_t;

    vec_t vecs [0:10];

    run_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .x0(x0), .x1(x1), .on0(on0), .on1(on1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .res_y(res_y), .res_s(res_s), .res_b(res_b),
        .u_x(u_x), .u_on(u_on), .u_start(u_start),
        .u_active(u_active), .u_y(u_y), .u_s(u_s), .u_b(u_b),
        .busy(busy), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        py = 8'd0; ps = 3'd0; pb = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        if (v.rb) do_reset();
        req0 = v.r0; req1 = v.r1; x0 = v.x0; x1 = v.x1; on0 = v.o0; on1 = v.o1;
        u_active = 1'b0;
        @(posedge clk); #1;   // IDLE -> ISSUE
        chk("ack", {30'd0, ack1, ack0}, v.eg ? 32'd2 : 32'd1);
        chk("u_start", {31'd0, u_start}, 32'd1);
        chk("u_x_u_on", {22'd0, u_x, u_on}, {22'd0, v.ex, v.eo});
        chk("gnt", {31'd0, gnt}, {31'd0, v.eg});
        chk("busy_issue", {31'd0, busy}, 32'd1);
        // requester side changes after ack must not disturb the job
        req0 = 1'b0; req1 = 1'b0; x0 = 8'hEE; x1 = 8'hEE; on0 = 2'd3; on1 = 2'd3;
        @(posedge clk); #1;   // ISSUE -> WAIT_ACT
        chk("issue_one_cycle", {29'd0, u_start, ack1, ack0}, 32'd0);
        u_active = 1'b1; u_y = v.y; u_s = v.s; u_b = v.b;
        for (int i = 0; i < int'(v.act); i++) begin
            @(posedge clk); #1;   // in RUN
            chk("run_hold", {8'd0, done1, done0, busy, res_y, res_s, res_b, u_x},
                {8'd0, 2'b00, 1'b1, py, ps, pb, v.ex});
        end
        u_active = 1'b0;
        @(posedge clk); #1;   // RUN -> DONE
        chk("done", {30'd0, done1, done0}, v.eg ? 32'd2 : 32'd1);
        chk("res", {20'd0, res_y, res_s, res_b}, {20'd0, v.y, v.s, v.b});
        chk("u_hold_done", {22'd0, u_x, u_on}, {22'd0, v.ex, v.eo});
        chk("no_err", {30'd0, err1, err0}, 32'd0);
        py = v.y; ps = v.s; pb = v.b;
        u_y = 8'h00; u_s = 3'd0; u_b = 1'b0;
        @(posedge clk); #1;   // DONE -> IDLE
        chk("idle_after_done", {29'd0, busy, done1, done0}, 32'd0);
        chk("res_keep", {20'd0, res_y, res_s, res_b}, {20'd0, py, ps, pb});
    endtask

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; x0 = 8'd0; x1 = 8'd0; on0 = 2'd0; on1 = 2'd0;
        u_active = 1'b0; u_y = 8'd0; u_s = 3'd0; u_b = 1'b0;
        py = 8'd0; ps = 3'd0; pb = 1'b0;

        //            rb    r0    r1    x0     x1     o0    o1    act   y      s     b     eg    ex     eo
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 2'd1, 2'd0, 4'd3, 8'hA5, 3'd4, 1'b1, 1'b0, 8'h5A, 2'd1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 2'd2, 2'd3, 4'd1, 8'h3C, 3'd1, 1'b0, 1'b1, 8'h22, 2'd3};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h33, 8'h44, 2'd0, 2'd1, 4'd2, 8'hC3, 3'd7, 1'b1, 1'b0, 8'h33, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h66, 2'd1, 2'd2, 4'd1, 8'h0F, 3'd2, 1'b0, 1'b1, 8'h66, 2'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 2'd0, 2'd3, 4'd1, 8'hF0, 3'd3, 1'b1, 1'b1, 8'h77, 2'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h88, 2'd0, 2'd0, 4'd2, 8'h12, 3'd5, 1'b0, 1'b1, 8'h88, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h99, 8'h00, 2'd2, 2'd0, 4'd1, 8'h34, 3'd6, 1'b1, 1'b0, 8'h99, 2'd2};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'hAB, 8'hCD, 2'd3, 2'd1, 4'd1, 8'h56, 3'd0, 1'b1, 1'b0, 8'hAB, 2'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 2'd0, 2'd1, 4'd2, 8'h78, 3'd1, 1'b0, 1'b1, 8'h02, 2'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h03, 8'h04, 2'd2, 2'd3, 4'd1, 8'h9A, 3'd2, 1'b1, 1'b0, 8'h03, 2'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h05, 8'h06, 2'd1, 2'd0, 4'd1, 8'hBC, 3'd3, 1'b0, 1'b1, 8'h06, 2'd0};

        // reset state
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_gnt", {31'd0, gnt}, 32'd1);
        chk("rst_unit", {21'd0, u_x, u_on, u_start}, 32'd0);
        chk("rst_res", {20'd0, res_y, res_s, res_b}, 32'd0);
        chk("rst_pulses", {26'd0, ack1, ack0, done1, done0, err1, err0}, 32'd0);

        for (int k = 0; k < 11; k++) run_job(vecs[k]);

        // stalled unit: u_active never rises after ISSUE
        req0 = 1'b1; x0 = 8'h21; on0 = 2'd1; u_active = 1'b0;
        @(posedge clk); #1;
        chk("stall_ack", {30'd0, ack1, ack0}, 32'd1);
        req0 = 1'b0;
`ifdef RUN_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("to_wait", {29'd0, busy, done0, err0}, 32'd4);
        end
        @(posedge clk); #1;
        chk("to_done_err", {30'd0, done0, err0}, 32'd3);
        chk("to_res_keep", {20'd0, res_y, res_s, res_b}, {20'd0, py, ps, pb});
        @(posedge clk); #1;
        chk("to_idle", {31'd0, busy}, 32'd0);
`else
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("no_timeout", {29'd0, busy, done0, err0}, 32'd4);
        end
        do_reset();
`endif

        // mid-RUN reset: job granted to 0, then reset while the unit is active
        req0 = 1'b1; x0 = 8'h42; on0 = 2'd1;
        @(posedge clk); #1;   // ISSUE
        chk("mid_ack", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        @(posedge clk); #1;   // WAIT_ACT
        u_active = 1'b1; u_y = 8'hFF; u_s = 3'd7; u_b = 1'b1;
        @(posedge clk); #1;   // RUN
        chk("mid_busy_run", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_async", {22'd0, busy, u_x, gnt}, {22'd0, 1'b0, 8'h00, 1'b1});
        @(posedge clk); #1;
        rst = 1'b1;
        py = 8'd0; ps = 3'd0; pb = 1'b0;
        chk("mid_rst_no_done", {29'd0, done1, done0, busy}, 32'd0);
        u_active = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_quiet", {17'd0, done1, done0, err0, busy, res_y, res_s, res_b}, 32'd0);
        run_job('{1'b0, 1'b1, 1'b1, 8'h61, 8'h62, 2'd2, 2'd1, 4'd1, 8'h7E, 3'd5, 1'b1, 1'b0, 8'h61, 2'd2});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/run_arbiter.md
RUN_ARBITER -- requirements
Module: run_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 32, is the maximum number of cycles spent in WAIT_ACT plus RUN before a job is aborted; it is used only when RUN_TIMEOUT_EN is defined.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Ports req0/req1, input, 1 bit each: job request from requester 0/1.
REQ-005 Ports x0/x1, input, 8 bits each: operand from requester 0/1.
REQ-006 Ports on0/on1, input, 2 bits each: mode from requester 0/1.
REQ-007 Ports ack0/ack1, output, 1 bit each: one-cycle pulse, job accepted for requester 0/1.
REQ-008 Ports done0/done1, output, 1 bit each: one-cycle pulse, job finished for requester 0/1.
REQ-009 Ports err0/err1, output, 1 bit each: one-cycle pulse, job aborted by timeout.
REQ-010 Ports res_y (8 bits), res_s (3 bits), res_b (1 bit), outputs: result of the last completed job.
REQ-011 Ports u_x (8 bits), u_on (2 bits), u_start (1 bit), outputs: drive the shared compute unit's x, on and start.
REQ-012 Ports u_active, u_y (8 bits), u_s (3 bits), u_b, inputs: the shared unit's active, y, s and b.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port gnt, output, 1 bit: index of the requester currently or last served.

Function
REQ-015 The FSM SHALL have five states: IDLE, ISSUE, WAIT_ACT, RUN and DONE; all outputs SHALL be registered.
REQ-016 IDLE: if req0 or req1 is sampled high, the block SHALL select one requester, latch its x/on into u_x/u_on, set gnt and go to ISSUE; otherwise it stays in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; with one request high, grant it regardless of history.
REQ-018 ISSUE lasts exactly one cycle: u_start=1 and ack<gnt>=1, then go to WAIT_ACT.
REQ-019 WAIT_ACT: on an edge with u_active=1 go to RUN; otherwise stay.
REQ-020 RUN: on an edge with u_active=0, capture u_y/u_s/u_b into res_y/res_s/res_b and go to DONE.
REQ-021 DONE lasts exactly one cycle: done<gnt>=1, then go to IDLE.
REQ-022 u_x and u_on SHALL hold their latched values from ISSUE through DONE and SHALL not change in IDLE.
REQ-023 Minimum latency from a req edge in IDLE to done: ack at +1, done at +4 when u_active is high for one cycle.
REQ-024 A requester SHALL hold req, x and on stable until its ack; req changes after ack SHALL be ignored until the next IDLE.
REQ-025 A req still high in IDLE after done is a new request and re-enters arbitration; back-to-back jobs therefore have one IDLE cycle between DONE and ISSUE.
REQ-026 res_* SHALL change only on the RUN-to-DONE edge (or on reset).

Reset
REQ-027 While rst=0, the block SHALL force IDLE immediately, without waiting for a clock edge.
REQ-028 On reset: all pulses, u_start, busy, u_x, u_on and res_* =0; gnt=1, so requester 0 wins the first contention.
REQ-029 A reset mid-job SHALL abandon the job with no done or err pulse.

Configuration
REQ-030 With RUN_TIMEOUT_EN defined, an 8-bit counter SHALL clear in ISSUE and increment each cycle in WAIT_ACT and RUN.
REQ-031 On reaching TIMEOUT, the block SHALL go to DONE, pulse err<gnt> together with done<gnt>, and leave res_* unchanged.
REQ-032 Without RUN_TIMEOUT_EN, there is no counter, err0/err1 are constant 0, and the block waits indefinitely.

Verification
REQ-033 Single request: req0=1, x0=8'h5A, on0=2'b01, u_active high for 3 cycles with u_y=8'hA5, u_s=3'd4, u_b=1 -> ack0 at +1, u_start one cycle with u_x=8'h5A, then done0 with res_y=8'hA5, res_s=4, res_b=1.
REQ-034 Contention after reset: req0=req1=1 held -> order of grants is 0, 1, 0, 1; each ack separated by one job plus one IDLE cycle.
REQ-035 Lone requester: only req1 high, repeated jobs -> every job granted to 1 with no gaps beyond REQ-025.
REQ-036 Mid-RUN reset: drop rst for 1 cycle while u_active=1 -> busy=0 immediately, no done pulse, next contention grants 0.
REQ-037 Timeout (macro defined, TIMEOUT=4): u_active held 0 after ISSUE -> done0 and err0 pulse 4 cycles after ISSUE, res_* unchanged; macro undefined -> busy stays 1 and err0 stays 0.
